pkmc_rowctrl: RTL and testbench
===============================

# pkmc_rowctrl

Row open/close sequencer for the PKMC SDRAM controller; it is the command-issuing counterpart of the row-hit tracking in the controller. On each access request it decides hit or miss against the currently open row and issues PRECHARGE/ACTIVATE with tRP/tRCD spacing before granting the access. It also closes the row for refresh and issues AUTO REFRESH. It sits between the main memory-controller FSM and the SDRAM command output mux.

## Interface
- ROW_W, 13, row address width
- TRP, 2, NOP cycles after PRECHARGE (1..255)
- TRCD, 2, NOP cycles after ACTIVATE (1..255)
- TRFC, 7, NOP cycles after AUTO REFRESH (1..255)
- IDLE_CLOSE, 64, idle OPEN cycles before auto-close (1..65535; used only with PKMC_IDLE_CLOSE_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  1  access request; held with row_addr stable until gnt
- row_addr  in  ROW_W  requested row
- refresh_req  in  1  refresh request level; held until refresh_ack
- cmd  out  3  {ras_n,cas_n,we_n}: NOP=111, ACT=011, PRE=010, REF=001
- addr  out  ROW_W  row on ACT, else 0; bit 10 = 1 on PRE (precharge all)
- gnt  out  1  one-cycle pulse: requested row open, column access may start
- refresh_ack  out  1  one-cycle pulse: refresh sequence complete
- row_valid  out  1  a row is open
- open_row  out  ROW_W  currently open row (valid when row_valid)

## Operation
- All outputs are registered. Reset values: cmd=111, addr=0, gnt=0, refresh_ack=0, row_valid=0, open_row=0, state CLOSED, counters 0.
- States: CLOSED, OPEN, PRE, PRE_WAIT, ACT, ACT_WAIT, REF, REF_WAIT.
- CLOSED: refresh_req -> REF; else req -> ACT.
- OPEN: refresh_req -> PRE (refresh path); else req with row_addr==open_row -> gnt pulse, stay; req with mismatch -> PRE (miss path).
- PRE: cmd=PRE, addr[10]=1, row_valid cleared; -> PRE_WAIT (TRP NOP cycles) -> REF if on the refresh path, CLOSED if on the idle path, ACT if on the miss path.
- ACT: cmd=ACT, addr=row_addr, open_row<=row_addr, row_valid<=1; -> ACT_WAIT (TRCD NOP cycles) -> OPEN with gnt pulsed in the first OPEN cycle.
- REF: cmd=REF; -> REF_WAIT (TRFC NOP cycles) -> CLOSED, refresh_ack pulsed in the first CLOSED cycle.
- req and refresh_req sampled in OPEN/CLOSED are ignored in a cycle where gnt or refresh_ack is high, which prevents double grants.
- Simultaneous req and refresh_req: refresh wins. req stays pending and is served afterwards from CLOSED via ACT.
- refresh_req rising during a miss sequence is not sampled until the sequence returns to OPEN/CLOSED.
- Wait counter: 8 bits, loaded with param-1 on state entry, exits at 0.
- Reset mid-sequence: outputs return to reset values immediately. No recovery PRE is issued; the SDRAM init sequence covers it.

## Timing
Requests are sampled at edge 0; cycles are counted from there.
- Hit in OPEN: gnt in cycle 1.
- From CLOSED: ACT in cycle 1, NOP in cycles 2..TRCD+1, gnt in cycle TRCD+2. With defaults, gnt in cycle 4.
- Miss: PRE in cycle 1, NOP in cycles 2..TRP+1, ACT in cycle TRP+2, gnt in cycle TRP+TRCD+3. With defaults, gnt in cycle 7.
- Refresh from OPEN: PRE in cycle 1, REF in cycle TRP+2, refresh_ack in cycle TRP+TRFC+3. With defaults, refresh_ack in cycle 12.
- Refresh from CLOSED: REF in cycle 1, refresh_ack in cycle TRFC+2.
- Back-to-back hits: gnt at most every 2 cycles.

## Configuration
- PKMC_IDLE_CLOSE_EN defined:
  - A 16-bit idle counter runs in OPEN and is cleared on gnt or whenever req is high.
  - When it reaches IDLE_CLOSE, the block enters PRE and then CLOSED with row_valid=0.
  - An auto-close that has started takes precedence over a req arriving during PRE/PRE_WAIT; that req is served from CLOSED.
- Not defined: no idle counter; a row stays open until a miss or a refresh.

## Test plan
- Reset, then req row 0x123 from CLOSED -> cmd=011/addr=0x123 in cycle 1, NOPs in cycles 2-3, gnt in cycle 4, row_valid=1, open_row=0x123.
- With row 0x123 open, req row 0x123 -> gnt in cycle 1, no PRE/ACT issued. Repeat 4 times -> 4 gnt pulses, each 2 cycles apart.
- With row 0x123 open, req row 0x050 -> PRE with addr[10]=1 in cycle 1, ACT 0x050 in cycle 4, gnt in cycle 7, open_row=0x050.
- With a row open, req and refresh_req rise together:
  - PRE in cycle 1, REF in cycle 4, refresh_ack in cycle 12.
  - Then ACT for the pending row in cycle 13, gnt in cycle 16.
- Assert rst during PRE_WAIT -> cmd=111, row_valid=0, gnt=0 immediately. The next req is served with CLOSED-path timing.
- PKMC_IDLE_CLOSE_EN with IDLE_CLOSE=8: grant a row, then hold req low -> PRE issued 8 cycles after gnt, row_valid=0 after the TRP wait. Without the macro -> no PRE for 100 cycles.

Source files
------------

// File: rtl/pkmc_rowctrl.sv
// pkmc_rowctrl: SDRAM row open/close sequencer issuing PRE/ACT/REF with tRP/tRCD/tRFC spacing.
// Optional idle auto-close of the open row is compiled in when PKMC_IDLE_CLOSE_EN is defined.
module pkmc_rowctrl #(
  parameter int ROW_W      = 13,
  parameter int TRP        = 2,
  parameter int TRCD       = 2,
  parameter int TRFC       = 7,
  parameter int IDLE_CLOSE = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [ROW_W-1:0] row_addr,
  input  logic             refresh_req,
  output logic [2:0]       cmd,
  output logic [ROW_W-1:0] addr,
  output logic             gnt,
  output logic             refresh_ack,
  output logic             row_valid,
  output logic [ROW_W-1:0] open_row
);

  localparam logic [2:0]       CMD_NOP = 3'b111;
  localparam logic [2:0]       CMD_ACT = 3'b011;
  localparam logic [2:0]       CMD_PRE = 3'b010;
  localparam logic [2:0]       CMD_REF = 3'b001;
  localparam logic [ROW_W-1:0] PRE_ALL = ROW_W'(1 << 10);

  typedef enum logic [2:0] {
    CLOSED, OPEN, PRE, PRE_WAIT, ACT, ACT_WAIT, REF, REF_WAIT
  } stateT;

  // Why the row is being precharged decides where PRE_WAIT leads.
  typedef enum logic [1:0] {PATH_MISS, PATH_REFRESH, PATH_IDLE} pathT;

  if (ROW_W < 11 || TRP < 1 || TRP > 255 || TRCD < 1 || TRCD > 255 ||
      TRFC < 1 || TRFC > 255 || IDLE_CLOSE < 1 || IDLE_CLOSE > 65535) begin : gBadParam
    $error("pkmc_rowctrl: parameter out of range");
  end

  stateT            state, stateNext;
  pathT             path, pathNext;
  logic [7:0]       waitCnt, waitCntNext;
  logic [2:0]       cmdNext;
  logic [ROW_W-1:0] addrNext, openRowNext;
  logic             gntNext, ackNext, rowValidNext;
  logic             reqSeen, refSeen, rowHit, idleExpire;

  // A request still held high in its own gnt/refresh_ack cycle must not be served twice.
  assign reqSeen = req && !gnt;
  assign refSeen = refresh_req && !gnt && !refresh_ack;
  assign rowHit  = (row_addr == open_row);

`ifdef PKMC_IDLE_CLOSE_EN
  logic [15:0] idleCnt;

  assign idleExpire = !req && (idleCnt == 16'(IDLE_CLOSE - 1));

  // Held at zero outside OPEN, so it restarts from zero whenever a grant re-enters OPEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          idleCnt <= '0;
    else if (state != OPEN || stateNext != OPEN || req) idleCnt <= '0;
    else                                              idleCnt <= idleCnt + 16'd1;
  end
`else
  assign idleExpire = 1'b0;
`endif

  always_comb begin
    // NOTE: every next-value defaults to hold/NOP first, so no latch is inferred.
    stateNext    = state;
    pathNext     = path;
    waitCntNext  = waitCnt;
    cmdNext      = CMD_NOP;
    addrNext     = '0;
    gntNext      = 1'b0;
    ackNext      = 1'b0;
    rowValidNext = row_valid;
    openRowNext  = open_row;

    case (state)
      CLOSED: begin
        if (refSeen)      stateNext = REF;
        else if (reqSeen) stateNext = ACT;
      end
      OPEN: begin
        if (refSeen) begin
          stateNext = PRE;
          pathNext  = PATH_REFRESH;
        end else if (reqSeen && rowHit) begin
          gntNext = 1'b1;
        end else if (reqSeen) begin
          stateNext = PRE;
          pathNext  = PATH_MISS;
        end else if (idleExpire) begin
          stateNext = PRE;
          pathNext  = PATH_IDLE;
        end
      end
      PRE:      stateNext = PRE_WAIT;
      PRE_WAIT: begin
        if (waitCnt != 8'd0)              waitCntNext = waitCnt - 8'd1;
        else if (path == PATH_REFRESH)    stateNext   = REF;
        else if (path == PATH_IDLE)       stateNext   = CLOSED;
        else                              stateNext   = ACT;
      end
      ACT:      stateNext = ACT_WAIT;
      ACT_WAIT: begin
        if (waitCnt != 8'd0) waitCntNext = waitCnt - 8'd1;
        else                 stateNext   = OPEN;
      end
      REF:      stateNext = REF_WAIT;
      REF_WAIT: begin
        if (waitCnt != 8'd0) waitCntNext = waitCnt - 8'd1;
        else                 stateNext   = CLOSED;
      end
    endcase

    // Outputs are registered with the actions of the state being entered.
    if (stateNext != state) begin
      case (stateNext)
        PRE: begin
          cmdNext      = CMD_PRE;
          addrNext     = PRE_ALL;
          rowValidNext = 1'b0;
        end
        ACT: begin
          cmdNext      = CMD_ACT;
          addrNext     = row_addr;
          openRowNext  = row_addr;
          rowValidNext = 1'b1;
        end
        REF:      cmdNext     = CMD_REF;
        PRE_WAIT: waitCntNext = 8'(TRP - 1);
        ACT_WAIT: waitCntNext = 8'(TRCD - 1);
        REF_WAIT: waitCntNext = 8'(TRFC - 1);
        OPEN:     gntNext     = 1'b1;
        CLOSED:   ackNext     = (state == REF_WAIT);
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CLOSED;
      path        <= PATH_MISS;
      waitCnt     <= '0;
      cmd         <= CMD_NOP;
      addr        <= '0;
      gnt         <= 1'b0;
      refresh_ack <= 1'b0;
      row_valid   <= 1'b0;
      open_row    <= '0;
    end else begin
      state       <= stateNext;
      path        <= pathNext;
      waitCnt     <= waitCntNext;
      cmd         <= cmdNext;
      addr        <= addrNext;
      gnt         <= gntNext;
      refresh_ack <= ackNext;
      row_valid   <= rowValidNext;
      open_row    <= openRowNext;
    end
  end

endmodule

// File: tb/tb_pkmc_rowctrl.sv
// Directed bench for pkmc_rowctrl: each step queues the command/grant events it should cause,
// and a falling-edge monitor pops and compares them (cycle stamp included) as the DUT emits them.
`timescale 1ns/1ps
module tb_pkmc_rowctrl;
  localparam int ROW_W      = 13;
  localparam int TRP        = 2;
  localparam int TRCD       = 2;
  localparam int TRFC       = 7;
  localparam int IDLE_CLOSE = 8;

  localparam logic [2:0]       NOP     = 3'b111;
  localparam logic [2:0]       ACT     = 3'b011;
  localparam logic [2:0]       PRE     = 3'b010;
  localparam logic [2:0]       REF     = 3'b001;
  localparam logic [ROW_W-1:0] PRE_ALL = 13'h0400;
  localparam logic [ROW_W-1:0] ZERO    = 13'h0000;

  typedef struct {
    int               cyc;
    logic [2:0]       cmd;
    logic [ROW_W-1:0] addr;
    logic             gnt;
    logic             ack;
  } evT;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req = 1'b0;
  logic             refresh_req = 1'b0;
  logic [ROW_W-1:0] row_addr = '0;
  logic [2:0]       cmd;
  logic [ROW_W-1:0] addr;
  logic             gnt, refresh_ack, row_valid;
  logic [ROW_W-1:0] open_row;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  evT sb[$];

  pkmc_rowctrl #(
    .ROW_W(ROW_W), .TRP(TRP), .TRCD(TRCD), .TRFC(TRFC), .IDLE_CLOSE(IDLE_CLOSE)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .row_addr(row_addr), .refresh_req(refresh_req),
    .cmd(cmd), .addr(addr), .gnt(gnt), .refresh_ack(refresh_ack),
    .row_valid(row_valid), .open_row(open_row)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expectEv(input int at, input logic [2:0] c, input logic [ROW_W-1:0] a,
                          input logic g, input logic k);
    evT e;
    e.cyc = at; e.cmd = c; e.addr = a; e.gnt = g; e.ack = k;
    sb.push_back(e);
  endtask

  // Every non-NOP command, grant or ack must match the oldest queued expectation.
  always @(negedge clk) begin
    evT e;
    if (!rst && (cmd !== NOP || gnt !== 1'b0 || refresh_ack !== 1'b0)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", 32'({cmd, gnt, refresh_ack}), 32'({NOP, 2'b00}));
      end else begin
        e = sb.pop_front();
        check("event_cycle", 32'(cyc), 32'(e.cyc));
        check("event_cmd", 32'(cmd), 32'(e.cmd));
        check("event_addr", 32'(addr), 32'(e.addr));
        check("event_gnt", 32'(gnt), 32'(e.gnt));
        check("event_ack", 32'(refresh_ack), 32'(e.ack));
      end
    end
  end

  task automatic startReq(input logic [ROW_W-1:0] row, output int c);
    @(negedge clk);
    req = 1'b1;
    row_addr = row;
    c = cyc;
  endtask

  task automatic waitGnt(input string tag, output int s);
    s = -1;
    for (int i = 0; i < 40 && s < 0; i++) begin
      @(negedge clk);
      if (gnt === 1'b1) s = cyc;
    end
    if (s < 0) check(tag, 32'(gnt), 32'd1);
    req = 1'b0;
  endtask

  initial begin
    int c, s, n;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cmd", 32'(cmd), 32'(NOP));
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ack", 32'(refresh_ack), 32'd0);
    check("rst_row_valid", 32'(row_valid), 32'd0);
    check("rst_open_row", 32'(open_row), 32'd0);
    rst = 1'b0;

    // Access from CLOSED: ACT in cycle 1, gnt in cycle TRCD+2
    startReq(13'h123, c);
    expectEv(c + 1, ACT, 13'h123, 1'b0, 1'b0);
    expectEv(c + TRCD + 2, NOP, ZERO, 1'b1, 1'b0);
    waitGnt("closed_gnt_timeout", s);
    check("closed_row_valid", 32'(row_valid), 32'd1);
    check("closed_open_row", 32'(open_row), 32'h123);

    // Four back-to-back hits with req held: grants every 2 cycles, no PRE/ACT
    startReq(13'h123, c);
    for (int k = 0; k < 4; k++) expectEv(c + 1 + 2 * k, NOP, ZERO, 1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      @(negedge clk);
      if (gnt === 1'b1) n++;
    end
    req = 1'b0;
    check("hit_gnt_count", 32'(n), 32'd4);

    // Miss: PRE-all, ACT in cycle TRP+2, gnt in cycle TRP+TRCD+3
    startReq(13'h050, c);
    expectEv(c + 1, PRE, PRE_ALL, 1'b0, 1'b0);
    expectEv(c + TRP + 2, ACT, 13'h050, 1'b0, 1'b0);
    expectEv(c + TRP + TRCD + 3, NOP, ZERO, 1'b1, 1'b0);
    waitGnt("miss_gnt_timeout", s);
    check("miss_open_row", 32'(open_row), 32'h050);
    check("miss_row_valid", 32'(row_valid), 32'd1);

    // req and refresh_req together: refresh first, pending row activated from CLOSED
    @(negedge clk);
    req = 1'b1;
    refresh_req = 1'b1;
    row_addr = 13'h0AA;
    c = cyc;
    expectEv(c + 1, PRE, PRE_ALL, 1'b0, 1'b0);
    expectEv(c + TRP + 2, REF, ZERO, 1'b0, 1'b0);
    expectEv(c + TRP + TRFC + 3, NOP, ZERO, 1'b0, 1'b1);
    expectEv(c + TRP + TRFC + 4, ACT, 13'h0AA, 1'b0, 1'b0);
    expectEv(c + TRP + TRFC + TRCD + 5, NOP, ZERO, 1'b1, 1'b0);
    s = -1;
    for (int i = 0; i < 60 && s < 0; i++) begin
      @(negedge clk);
      if (refresh_ack === 1'b1) refresh_req = 1'b0;
      if (gnt === 1'b1) s = cyc;
    end
    if (s < 0) check("refresh_gnt_timeout", 32'(gnt), 32'd1);
    req = 1'b0;
    refresh_req = 1'b0;
    check("refresh_open_row", 32'(open_row), 32'h0AA);

    // Reset during PRE_WAIT of a miss, then CLOSED-path timing
    startReq(13'h111, c);
    expectEv(c + 1, PRE, PRE_ALL, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_row_valid", 32'(row_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    #1;
    check("midrst_cmd", 32'(cmd), 32'(NOP));
    check("midrst_row_valid", 32'(row_valid), 32'd0);
    check("midrst_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    startReq(13'h111, c);
    expectEv(c + 1, ACT, 13'h111, 1'b0, 1'b0);
    expectEv(c + TRCD + 2, NOP, ZERO, 1'b1, 1'b0);
    waitGnt("postrst_gnt_timeout", s);
    check("postrst_open_row", 32'(open_row), 32'h111);

`ifdef PKMC_IDLE_CLOSE_EN
    // Idle auto-close: PRE IDLE_CLOSE cycles after gnt, then CLOSED
    expectEv(s + IDLE_CLOSE, PRE, PRE_ALL, 1'b0, 1'b0);
    repeat (IDLE_CLOSE + TRP + 2) @(negedge clk);
    check("idle_row_valid", 32'(row_valid), 32'd0);
    startReq(13'h111, c);
    expectEv(c + 1, ACT, 13'h111, 1'b0, 1'b0);
    expectEv(c + TRCD + 2, NOP, ZERO, 1'b1, 1'b0);
    waitGnt("idle_reopen_gnt_timeout", s);
`else
    // No auto-close: row stays open through 100 idle cycles
    repeat (100) @(negedge clk);
    check("noidle_row_valid", 32'(row_valid), 32'd1);
    check("noidle_open_row", 32'(open_row), 32'h111);
`endif

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
